// File: rtl/adjmat_arbiter.sv
// Arbitrates the single AdjMat RAM port between the edge updater (writes) and
// the Bellman / cycle-detect readers, with lock bursts and updater starvation guard.
module adjmat_arbiter #(
  parameter int unsigned VERT_WIDTH    = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RD_LAT        = 1,
  parameter int unsigned MAX_UPD_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  upd_req,
  input  logic [VERT_WIDTH-1:0] upd_row,
  input  logic [VERT_WIDTH-1:0] upd_col,
  input  logic [DATA_WIDTH-1:0] upd_data,
  output logic                  upd_gnt,
  input  logic                  bel_req,
  input  logic                  bel_lock,
  input  logic [VERT_WIDTH-1:0] bel_row,
  input  logic [VERT_WIDTH-1:0] bel_col,
  output logic                  bel_gnt,
  output logic                  bel_rvalid,
  output logic [DATA_WIDTH-1:0] bel_rdata,
  input  logic                  cyc_req,
  input  logic                  cyc_lock,
  input  logic [VERT_WIDTH-1:0] cyc_row,
  input  logic [VERT_WIDTH-1:0] cyc_col,
  output logic                  cyc_gnt,
  output logic                  cyc_rvalid,
  output logic [DATA_WIDTH-1:0] cyc_rdata,
  output logic [VERT_WIDTH-1:0] mem_row_addr,
  output logic [VERT_WIDTH-1:0] mem_col_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy
);

  typedef enum logic [1:0] {OWN_IDLE, OWN_UPD, OWN_BEL, OWN_CYC} owner_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_BEL, TAG_CYC} tag_e;

  localparam int unsigned SW = $clog2(MAX_UPD_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_UPD_BURST);

  owner_e                owner_q, owner_d, rr_pick;
  logic                  rr_cyc_q, rr_cyc_d;
  logic [SW-1:0]         streak_q, streak_d;
  tag_e                  tag_q [RD_LAT];
  tag_e                  tag_d [RD_LAT];
  logic [VERT_WIDTH-1:0] row_q, row_d, col_q, col_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rd_any, in_flight;

  // owner_d is this cycle's winner; it becomes next cycle's owner.
  always_comb begin
    rd_any = bel_req | cyc_req;
    if (bel_req && cyc_req) rr_pick = rr_cyc_q ? OWN_BEL : OWN_CYC;
    else                    rr_pick = bel_req  ? OWN_BEL : OWN_CYC;

    owner_d = OWN_IDLE;
    if (owner_q == OWN_BEL && bel_lock && bel_req)       owner_d = OWN_BEL;
    else if (owner_q == OWN_CYC && cyc_lock && cyc_req)  owner_d = OWN_CYC;
    else if (streak_q == STREAK_MAX && rd_any)           owner_d = rr_pick;
    else if (upd_req)                                    owner_d = OWN_UPD;
    else if (rd_any)                                     owner_d = rr_pick;

    // Grants must be dead the instant reset asserts, not at the next edge.
    if (!reset) owner_d = OWN_IDLE;
  end

  always_comb begin
    streak_d = '0;
    rr_cyc_d = rr_cyc_q;
    row_d    = row_q;
    col_d    = col_q;
    data_d   = data_q;
    tag_d[0] = TAG_NONE;
    for (int unsigned i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];

    unique case (owner_d)
      OWN_UPD: begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
        row_d    = upd_row;
        col_d    = upd_col;
        data_d   = upd_data;
      end
      OWN_BEL: begin
        rr_cyc_d = 1'b0;
        row_d    = bel_row;
        col_d    = bel_col;
        tag_d[0] = TAG_BEL;
      end
      OWN_CYC: begin
        rr_cyc_d = 1'b1;
        row_d    = cyc_row;
        col_d    = cyc_col;
        tag_d[0] = TAG_CYC;
      end
      default: ;
    endcase

    in_flight = 1'b0;
    for (int unsigned i = 0; i < RD_LAT; i++) in_flight |= (tag_q[i] != TAG_NONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q  <= OWN_IDLE;
      rr_cyc_q <= 1'b1;
      streak_q <= '0;
      tag_q    <= '{default: TAG_NONE};
      row_q    <= '0;
      col_q    <= '0;
      data_q   <= '0;
    end else begin
      owner_q  <= owner_d;
      rr_cyc_q <= rr_cyc_d;
      streak_q <= streak_d;
      tag_q    <= tag_d;
      row_q    <= row_d;
      col_q    <= col_d;
      data_q   <= data_d;
    end
  end

  assign upd_gnt      = (owner_d == OWN_UPD);
  assign bel_gnt      = (owner_d == OWN_BEL);
  assign cyc_gnt      = (owner_d == OWN_CYC);
  assign mem_we       = upd_gnt;
  assign mem_row_addr = row_d;
  assign mem_col_addr = col_d;
  assign mem_data     = data_d;
  assign bel_rvalid   = (tag_q[RD_LAT-1] == TAG_BEL);
  assign cyc_rvalid   = (tag_q[RD_LAT-1] == TAG_CYC);
  assign bel_rdata    = mem_q;
  assign cyc_rdata    = mem_q;
  assign busy         = (owner_d != OWN_IDLE) | in_flight;

endmodule

// File: tb/tb_adjmat_arbiter.sv
// Bench for adjmat_arbiter: behavioural RAM with write-first reads, a
// rule-level arbitration model with a read scoreboard, and directed scenarios.
module tb_adjmat_arbiter;
  localparam int VW     = 5;
  localparam int DW     = 32;
  localparam int RD_LAT = 3;
  localparam int MAXB   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          upd_req = 1'b0, bel_req = 1'b0, cyc_req = 1'b0;
  logic          bel_lock = 1'b0, cyc_lock = 1'b0;
  logic [VW-1:0] upd_row = '0, upd_col = '0, bel_row = '0, bel_col = '0;
  logic [VW-1:0] cyc_row = '0, cyc_col = '0;
  logic [DW-1:0] upd_data = '0;
  logic          upd_gnt, bel_gnt, cyc_gnt, bel_rvalid, cyc_rvalid, mem_we, busy;
  logic [DW-1:0] bel_rdata, cyc_rdata, mem_data, mem_q;
  logic [VW-1:0] mem_row_addr, mem_col_addr;

  logic          pl_we = 1'b0;
  logic [9:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] rd_pipe [RD_LAT];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Reference model state
  int            m_prev, m_streak, m_rr;
  logic [DW-1:0] ref_mem [1024];
  int            q_due[$];
  int            q_who[$];
  logic [DW-1:0] q_data[$];
  int            obs_w = 0;
  logic          obs_bv, obs_cv;
  logic [DW-1:0] obs_bd;

  adjmat_arbiter #(
    .VERT_WIDTH(VW), .DATA_WIDTH(DW), .RD_LAT(RD_LAT), .MAX_UPD_BURST(MAXB)
  ) dut (
    .clk(clk), .reset(reset),
    .upd_req(upd_req), .upd_row(upd_row), .upd_col(upd_col), .upd_data(upd_data),
    .upd_gnt(upd_gnt),
    .bel_req(bel_req), .bel_lock(bel_lock), .bel_row(bel_row), .bel_col(bel_col),
    .bel_gnt(bel_gnt), .bel_rvalid(bel_rvalid), .bel_rdata(bel_rdata),
    .cyc_req(cyc_req), .cyc_lock(cyc_lock), .cyc_row(cyc_row), .cyc_col(cyc_col),
    .cyc_gnt(cyc_gnt), .cyc_rvalid(cyc_rvalid), .cyc_rdata(cyc_rdata),
    .mem_row_addr(mem_row_addr), .mem_col_addr(mem_col_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_q(mem_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // AdjMat stand-in: write-first, RD_LAT-cycle read pipeline
  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[{mem_row_addr, mem_col_addr}] <= mem_data;
    rd_pipe[0] <= mem_we ? mem_data : ram[{mem_row_addr, mem_col_addr}];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_q = rd_pipe[RD_LAT-1];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Winner codes: 0 idle, 1 updater, 2 Bellman, 3 cycle detector
  function automatic int predict();
    int  rd_pick;
    bit  any_rd;
    any_rd = bel_req || cyc_req;
    if (bel_req && cyc_req) rd_pick = (m_rr == 3) ? 2 : 3;
    else                    rd_pick = bel_req ? 2 : 3;
    if (m_prev == 2 && bel_lock && bel_req) return 2;
    if (m_prev == 3 && cyc_lock && cyc_req) return 3;
    if (m_streak >= MAXB && any_rd)         return rd_pick;
    if (upd_req)                            return 1;
    if (any_rd)                             return rd_pick;
    return 0;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_streak = 0; m_rr = 3;
    q_due.delete(); q_who.delete(); q_data.delete();
  endtask

  task automatic run_cycle();
    int            w;
    logic [9:0]    ea;
    bit            exp_bv, exp_cv, in_fl;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    w = predict();
    obs_w  = upd_gnt ? 1 : bel_gnt ? 2 : cyc_gnt ? 3 : 0;
    obs_bv = bel_rvalid; obs_cv = cyc_rvalid; obs_bd = bel_rdata;

    n_checks++;
    if ({upd_gnt, bel_gnt, cyc_gnt} !== {w == 1, w == 2, w == 3}) begin
      n_fail++;
      $display("FAIL gnt @%0d: got u/b/c=%b%b%b expected winner %0d", cyc_n, upd_gnt, bel_gnt, cyc_gnt, w);
    end
    n_checks++;
    if (mem_we !== (w == 1)) begin
      n_fail++; $display("FAIL mem_we @%0d: got %b expected %b", cyc_n, mem_we, w == 1);
    end
    if (w != 0) begin
      ea = (w == 1) ? {upd_row, upd_col} : (w == 2) ? {bel_row, bel_col} : {cyc_row, cyc_col};
      n_checks++;
      if ({mem_row_addr, mem_col_addr} !== ea) begin
        n_fail++; $display("FAIL mem_addr @%0d: got %h expected %h", cyc_n, {mem_row_addr, mem_col_addr}, ea);
      end
      if (w == 1) begin
        n_checks++;
        if (mem_data !== upd_data) begin
          n_fail++; $display("FAIL mem_data @%0d: got %h expected %h", cyc_n, mem_data, upd_data);
        end
      end
    end

    exp_bv = 0; exp_cv = 0; exp_d = '0;
    if (q_due.size() > 0 && q_due[0] == cyc_n) begin
      exp_bv = (q_who[0] == 2); exp_cv = (q_who[0] == 3); exp_d = q_data[0];
    end
    n_checks++;
    if ({bel_rvalid, cyc_rvalid} !== {exp_bv, exp_cv}) begin
      n_fail++; $display("FAIL rvalid @%0d: got b/c=%b%b expected %b%b", cyc_n, bel_rvalid, cyc_rvalid, exp_bv, exp_cv);
    end
    if (exp_bv) begin
      n_checks++;
      if (bel_rdata !== exp_d) begin
        n_fail++; $display("FAIL bel_rdata @%0d: got %h expected %h", cyc_n, bel_rdata, exp_d);
      end
    end
    if (exp_cv) begin
      n_checks++;
      if (cyc_rdata !== exp_d) begin
        n_fail++; $display("FAIL cyc_rdata @%0d: got %h expected %h", cyc_n, cyc_rdata, exp_d);
      end
    end
    in_fl = (q_due.size() > 0);
    n_checks++;
    if (busy !== (w != 0 || in_fl)) begin
      n_fail++; $display("FAIL busy @%0d: got %b expected %b", cyc_n, busy, (w != 0 || in_fl));
    end

    if (exp_bv || exp_cv) begin
      void'(q_due.pop_front()); void'(q_who.pop_front()); void'(q_data.pop_front());
    end
    case (w)
      1: begin
        ref_mem[{upd_row, upd_col}] = upd_data;
        m_streak = (m_streak < MAXB) ? m_streak + 1 : MAXB;
      end
      2, 3: begin
        ea = (w == 2) ? {bel_row, bel_col} : {cyc_row, cyc_col};
        q_due.push_back(cyc_n + RD_LAT); q_who.push_back(w); q_data.push_back(ref_mem[ea]);
        m_streak = 0; m_rr = w;
      end
      default: m_streak = 0;
    endcase
    m_prev = w;
    @(posedge clk); cyc_n++; #1;
  endtask

  task automatic clear_reqs();
    upd_req = 0; bel_req = 0; cyc_req = 0; bel_lock = 0; cyc_lock = 0;
  endtask

  task automatic apply_reset();
    clear_reqs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic drain();
    clear_reqs();
    repeat (RD_LAT + 1) run_cycle();
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 1024; i++) begin
      v = (i == 3 * 32 + 7) ? 32'h0000_1234 : $urandom;
      pl_we = 1'b1; pl_addr = 10'(i); pl_data = v; ref_mem[i] = v;
      upd_req = 1'($urandom); bel_req = 1'($urandom); cyc_req = 1'($urandom);
      bel_lock = 1'($urandom); cyc_lock = 1'($urandom);
      #1;
      if (i % 256 == 0) begin
        n_checks++;
        if ({upd_gnt, bel_gnt, cyc_gnt} !== 3'b000) begin
          n_fail++; $display("FAIL reset_gnt: got %b%b%b expected 000", upd_gnt, bel_gnt, cyc_gnt);
        end
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", mem_we); end
        n_checks++;
        if ({bel_rvalid, cyc_rvalid} !== 2'b00) begin
          n_fail++; $display("FAIL reset_rvalid: got %b%b expected 00", bel_rvalid, cyc_rvalid);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      end
      @(posedge clk); #1;
    end
    pl_we = 1'b0;
    clear_reqs();
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_single_read();
    apply_reset();
    bel_req = 1; bel_row = 5'd3; bel_col = 5'd7;
    run_cycle();
    n_checks++;
    if (obs_w !== 2) begin n_fail++; $display("FAIL single_gnt: got winner %0d expected 2", obs_w); end
    bel_req = 0;
    for (int i = 1; i <= RD_LAT; i++) begin
      run_cycle();
      n_checks++;
      if (i < RD_LAT && obs_bv !== 1'b0) begin
        n_fail++; $display("FAIL single_early: rvalid at offset %0d, expected only at %0d", i, RD_LAT);
      end else if (i == RD_LAT && {obs_bv, obs_cv, obs_bd} !== {2'b10, 32'h0000_1234}) begin
        n_fail++; $display("FAIL single_data: got bv=%b cv=%b data=%h expected 1 0 00001234", obs_bv, obs_cv, obs_bd);
      end
    end
  endtask

  task automatic test_starvation();
    string pat = "UUUUBUUUUBUU";
    int    e;
    apply_reset();
    upd_req = 1; bel_req = 1;
    for (int i = 0; i < 12; i++) begin
      upd_row = VW'($urandom); upd_col = VW'($urandom); upd_data = $urandom;
      bel_row = VW'($urandom); bel_col = VW'($urandom);
      run_cycle();
      e = (pat[i] == "U") ? 1 : 2;
      n_checks++;
      if (obs_w !== e) begin n_fail++; $display("FAIL starve_pattern[%0d]: got winner %0d expected %0d", i, obs_w, e); end
    end
    drain();
  endtask

  task automatic test_round_robin();
    int e;
    apply_reset();
    bel_req = 1; cyc_req = 1;
    for (int i = 0; i < 8; i++) begin
      bel_row = VW'($urandom); bel_col = VW'($urandom);
      cyc_row = VW'($urandom); cyc_col = VW'($urandom);
      run_cycle();
      e = (i % 2 == 0) ? 2 : 3;
      n_checks++;
      if (obs_w !== e) begin n_fail++; $display("FAIL rr[%0d]: got winner %0d expected %0d", i, obs_w, e); end
    end
    drain();
  endtask

  task automatic test_lock();
    bit found = 0;
    apply_reset();
    upd_req = 1; bel_req = 1; cyc_req = 1; cyc_lock = 1;
    run_cycle();
    n_checks++;
    if (obs_w !== 1) begin n_fail++; $display("FAIL lock_first: got winner %0d expected 1", obs_w); end
    for (int k = 0; k < 20 && !found; k++) begin
      run_cycle();
      if (obs_w == 3) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL lock_acquire: got no cyc grant in 20 cycles, expected one"); end
    for (int k = 0; k < 4; k++) begin
      run_cycle();
      n_checks++;
      if (obs_w !== 3) begin n_fail++; $display("FAIL lock_hold[%0d]: got winner %0d expected 3", k, obs_w); end
    end
    cyc_lock = 0;
    run_cycle();
    n_checks++;
    if (obs_w !== 1) begin n_fail++; $display("FAIL lock_release: got winner %0d expected 1", obs_w); end
    drain();
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    bel_req = 1; cyc_req = 1;
    bel_row = 5'd1; bel_col = 5'd2; cyc_row = 5'd3; cyc_col = 5'd4;
    run_cycle();
    run_cycle();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({upd_gnt, bel_gnt, cyc_gnt, busy, bel_rvalid, cyc_rvalid} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got gnt=%b%b%b busy=%b rv=%b%b expected all 0",
               upd_gnt, bel_gnt, cyc_gnt, busy, bel_rvalid, cyc_rvalid);
    end
    model_reset();
    clear_reqs();
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < RD_LAT + 2; i++) begin
      run_cycle();
      n_checks++;
      if ({obs_bv, obs_cv} !== 2'b00) begin
        n_fail++; $display("FAIL midreset_stale[%0d]: got rvalid b/c=%b%b expected 00", i, obs_bv, obs_cv);
      end
    end
    bel_req = 1; cyc_req = 1;
    run_cycle();
    n_checks++;
    if (obs_w !== 2) begin n_fail++; $display("FAIL midreset_tie: got winner %0d expected 2", obs_w); end
    drain();
  endtask

  task automatic test_write_then_read();
    apply_reset();
    upd_req = 1; upd_row = 5'd2; upd_col = 5'd2; upd_data = 32'h0000_DEAD;
    run_cycle();
    upd_req = 0;
    bel_req = 1; bel_row = 5'd2; bel_col = 5'd2;
    run_cycle();
    bel_req = 0;
    repeat (RD_LAT) run_cycle();
    n_checks++;
    if ({obs_bv, obs_bd} !== {1'b1, 32'h0000_DEAD}) begin
      n_fail++; $display("FAIL raw_data: got bv=%b data=%h expected 1 0000dead", obs_bv, obs_bd);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      if (!upd_req || obs_w == 1) begin
        upd_row = VW'($urandom); upd_col = VW'($urandom); upd_data = $urandom;
      end
      if (!bel_req || obs_w == 2) begin bel_row = VW'($urandom); bel_col = VW'($urandom); end
      if (!cyc_req || obs_w == 3) begin cyc_row = VW'($urandom); cyc_col = VW'($urandom); end
      upd_req  = ($urandom_range(0, 3) != 0);
      bel_req  = ($urandom_range(0, 2) != 0);
      cyc_req  = ($urandom_range(0, 2) != 0);
      bel_lock = ($urandom_range(0, 3) == 0);
      cyc_lock = ($urandom_range(0, 3) == 0);
      run_cycle();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_starvation();
    test_round_robin();
    test_lock();
    test_reset_mid_read();
    test_write_then_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
